enet_rx_filter: RTL and testbench

Receive-side frame filter and sequencer between the MII receive byte stream and the receive FIFO. It is configured by the RCR/ECR control fields and the station MAC address, and makes the per-frame decisions on the fly:
- accept or reject by destination address,
- length policing and truncation,
- CRC strip or forward,
- pause-frame detection and extraction.

Output is a byte stream plus a per-frame end strobe that carries the discard verdict for the downstream FIFO.

---
 rtl/enet_rx_filter.sv | 255 +++++++++++++++++++++++++
 tb/tb_enet_rx_filter.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/enet_rx_filter.sv
// enet_rx_filter
// Receive-side frame filter between the MII receive byte stream and the
// receive FIFO. It checks the destination address, polices the frame length
// and truncates long frames. It strips or forwards the CRC and extracts the
// quanta of pause frames.
//
// Ports
//   rx_clk, rst            clock, synchronous active-high reset
//   ether_en .. crcfwd     RCR/ECR control bits, latched at frame start
//   max_fl                 maximum frame length in bytes, CRC included
//   mac_addr               station address, [47:40] first on the wire
//   in_valid/in_data       input byte stream, no backpressure
//   in_last/in_crc_err     end of frame and MAC CRC status
//   out_valid/out_data     output byte stream
//   out_eof                end-of-frame strobe carrying out_drop,
//                          out_trunc and out_crc_err
//   pause_valid            pulse when a pause frame is accepted;
//                          pause_quanta holds its value until the next pulse
//   overrun                pulse when a byte arrives during FLUSH/EOF
module enet_rx_filter (
  input  logic        rx_clk,
  input  logic        rst,
  input  logic        ether_en,
  input  logic        prom,
  input  logic        bc_rej,
  input  logic        fce,
  input  logic        paufwd,
  input  logic        crcfwd,
  input  logic [13:0] max_fl,
  input  logic [47:0] mac_addr,
  input  logic        in_valid,
  input  logic [7:0]  in_data,
  input  logic        in_last,
  input  logic        in_crc_err,
  output logic        out_valid,
  output logic [7:0]  out_data,
  output logic        out_eof,
  output logic        out_drop,
  output logic        out_trunc,
  output logic        out_crc_err,
  output logic        pause_valid,
  output logic [15:0] pause_quanta,
  output logic        overrun
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_RECV  = 3'd1,
    S_SKIP  = 3'd2,
    S_FLUSH = 3'd3,
    S_EOF   = 3'd4
  } state_t;

  state_t      state, state_nx;

  // Per-frame latched configuration
  logic        prom_r, bc_rej_r, fce_r, paufwd_r, crcfwd_r;
  logic [13:0] max_fl_r;
  logic [39:0] mac_lo_r;   // bytes 1..5 of the station address

  logic [13:0] n;          // accepted byte count, saturating
  logic [31:0] dline;      // 4-byte delay line, [31:24] is the oldest byte
  logic [1:0]  flush_cnt;
  logic        da_match, da_bc, da_mc, pau_ok, crc_err_r;
  logic [15:0] pq;

  // Combinational helpers
  logic        take, fwd_now;
  logic [13:0] idx, idx_inc;
  logic [7:0]  mac_byte, pau_exp;
  logic        pau_chk;
  logic        norm_out, fl_out;
  logic [14:0] fl_idx;
  logic        accept, pause_det, too_long, drop_s, pause_hit;

  // Next-state logic
  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE: begin
        if (in_valid) begin
          if (!ether_en)    state_nx = in_last ? S_IDLE : S_SKIP;
          else if (in_last) state_nx = crcfwd ? S_FLUSH : S_EOF;
          else              state_nx = S_RECV;
        end
      end
      S_RECV: begin
        if (in_valid && in_last) state_nx = crcfwd_r ? S_FLUSH : S_EOF;
      end
      S_SKIP: begin
        if (in_valid && in_last) state_nx = S_IDLE;
      end
      S_FLUSH: begin
        if (flush_cnt == 2'd3) state_nx = S_EOF;
      end
      S_EOF:   state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  // Byte acceptance, index and expected address/pause bytes
  always_comb begin
    fwd_now  = (state == S_IDLE) ? crcfwd : crcfwd_r;
    take     = in_valid && (((state == S_IDLE) && ether_en) || (state == S_RECV));
    idx      = (state == S_IDLE) ? 14'd0 : n;
    idx_inc  = (idx == 14'h3FFF) ? idx : idx + 14'd1;
    mac_byte = 8'h00;
    case (idx)
      14'd0:   mac_byte = mac_addr[47:40];   // latch happens this same cycle
      14'd1:   mac_byte = mac_lo_r[39:32];
      14'd2:   mac_byte = mac_lo_r[31:24];
      14'd3:   mac_byte = mac_lo_r[23:16];
      14'd4:   mac_byte = mac_lo_r[15:8];
      14'd5:   mac_byte = mac_lo_r[7:0];
      default: mac_byte = 8'h00;
    endcase
    pau_exp = 8'h00;
    pau_chk = 1'b1;
    case (idx)
      14'd0:   pau_exp = 8'h01;
      14'd1:   pau_exp = 8'h80;
      14'd2:   pau_exp = 8'hC2;
      14'd3:   pau_exp = 8'h00;
      14'd4:   pau_exp = 8'h00;
      14'd5:   pau_exp = 8'h01;
      14'd12:  pau_exp = 8'h88;
      14'd13:  pau_exp = 8'h08;
      14'd14:  pau_exp = 8'h00;
      14'd15:  pau_exp = 8'h01;
      default: pau_chk = 1'b0;
    endcase
    // Byte idx-4 leaves the delay line; suppressed beyond max_fl
    norm_out = (idx >= 14'd4) && (({1'b0, idx} - 15'd4) < {1'b0, max_fl_r});
    // During FLUSH the outgoing byte index is n-4+flush_cnt
    fl_idx   = {1'b0, n} - 15'd4 + {13'd0, flush_cnt};
    fl_out   = (n >= 14'd5) && (fl_idx < {1'b0, max_fl_r});
  end

  // End-of-frame verdict
  always_comb begin
    accept    = prom_r || da_match || (da_bc && !bc_rej_r) || (da_mc && !da_bc);
    pause_det = pau_ok && (n >= 14'd18);
    too_long  = (n > max_fl_r);
    drop_s    = !accept || (n < 14'd64) || crc_err_r || too_long ||
                (fce_r && pause_det && !paufwd_r);
    pause_hit = fce_r && pause_det && !crc_err_r && (n >= 14'd64) && !too_long;
  end

  // State register
  always_ff @(posedge rx_clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nx;
  end

  // Datapath: config latch, counter, delay line, address/pause tracking, outputs
  always_ff @(posedge rx_clk) begin
    if (rst) begin
      prom_r       <= 1'b0;
      bc_rej_r     <= 1'b0;
      fce_r        <= 1'b0;
      paufwd_r     <= 1'b0;
      crcfwd_r     <= 1'b0;
      max_fl_r     <= 14'd0;
      mac_lo_r     <= 40'd0;
      n            <= 14'd0;
      dline        <= 32'd0;
      flush_cnt    <= 2'd0;
      da_match     <= 1'b0;
      da_bc        <= 1'b0;
      da_mc        <= 1'b0;
      pau_ok       <= 1'b0;
      crc_err_r    <= 1'b0;
      pq           <= 16'd0;
      out_valid    <= 1'b0;
      out_data     <= 8'd0;
      out_eof      <= 1'b0;
      out_drop     <= 1'b0;
      out_trunc    <= 1'b0;
      out_crc_err  <= 1'b0;
      pause_valid  <= 1'b0;
      pause_quanta <= 16'd0;
      overrun      <= 1'b0;
    end else begin
      out_valid   <= 1'b0;
      out_eof     <= 1'b0;
      out_drop    <= 1'b0;
      out_trunc   <= 1'b0;
      out_crc_err <= 1'b0;
      pause_valid <= 1'b0;
      overrun     <= 1'b0;

      if ((state == S_IDLE) && in_valid) begin
        prom_r   <= prom;
        bc_rej_r <= bc_rej;
        fce_r    <= fce;
        paufwd_r <= paufwd;
        crcfwd_r <= crcfwd;
        max_fl_r <= max_fl;
        mac_lo_r <= mac_addr[39:0];
      end

      if (take) begin
        n     <= idx_inc;
        dline <= {dline[23:0], in_data};
        if (norm_out) begin
          out_valid <= 1'b1;
          out_data  <= dline[31:24];
        end
        if (idx == 14'd0) begin
          da_match <= (in_data == mac_byte);
          da_bc    <= (in_data == 8'hFF);
          da_mc    <= in_data[0];
          pau_ok   <= (in_data == pau_exp);
        end else begin
          if (idx < 14'd6) begin
            da_match <= da_match && (in_data == mac_byte);
            da_bc    <= da_bc && (in_data == 8'hFF);
          end
          if (pau_chk) pau_ok <= pau_ok && (in_data == pau_exp);
          if (idx == 14'd16) pq[15:8] <= in_data;
          if (idx == 14'd17) pq[7:0]  <= in_data;
        end
        if (in_last) begin
          crc_err_r <= in_crc_err;
          flush_cnt <= 2'd0;
          if (!fwd_now) dline <= 32'd0;
        end
      end

      if (state == S_FLUSH) begin
        flush_cnt <= flush_cnt + 2'd1;
        dline     <= {dline[23:0], 8'h00};
        if (fl_out) begin
          out_valid <= 1'b1;
          out_data  <= dline[31:24];
        end
      end

      if (((state == S_FLUSH) || (state == S_EOF)) && in_valid) overrun <= 1'b1;

      if (state == S_EOF) begin
        out_eof     <= 1'b1;
        out_drop    <= drop_s;
        out_trunc   <= too_long;
        out_crc_err <= crc_err_r;
        if (pause_hit) begin
          pause_valid  <= 1'b1;
          pause_quanta <= pq;
        end
        dline <= 32'd0;
      end
    end
  end

endmodule

// File: tb/tb_enet_rx_filter.sv
// Self-checking bench for enet_rx_filter: a table of frame scenarios with
// hand-computed verdicts, plus hand-written sequences for disable, mid-frame
// reset and overrun.
module tb_enet_rx_filter;

  logic        rx_clk = 1'b0;
  logic        rst, ether_en, prom, bc_rej, fce, paufwd, crcfwd;
  logic [13:0] max_fl;
  logic [47:0] mac_addr;
  logic        in_valid, in_last, in_crc_err;
  logic [7:0]  in_data;
  logic        out_valid, out_eof, out_drop, out_trunc, out_crc_err;
  logic        pause_valid, overrun;
  logic [7:0]  out_data;
  logic [15:0] pause_quanta;

  enet_rx_filter dut (
    .rx_clk(rx_clk), .rst(rst), .ether_en(ether_en), .prom(prom),
    .bc_rej(bc_rej), .fce(fce), .paufwd(paufwd), .crcfwd(crcfwd),
    .max_fl(max_fl), .mac_addr(mac_addr), .in_valid(in_valid),
    .in_data(in_data), .in_last(in_last), .in_crc_err(in_crc_err),
    .out_valid(out_valid), .out_data(out_data), .out_eof(out_eof),
    .out_drop(out_drop), .out_trunc(out_trunc), .out_crc_err(out_crc_err),
    .pause_valid(pause_valid), .pause_quanta(pause_quanta), .overrun(overrun)
  );

  always #5 rx_clk = ~rx_clk;

  int cyc = 0;
  always @(posedge rx_clk) cyc <= cyc + 1;

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  localparam logic [47:0] MAC_OWN   = 48'h02_11_22_33_44_55;
  localparam logic [47:0] MAC_OTHER = 48'h02_AA_BB_CC_DD_EE;
  localparam logic [47:0] MAC_PAUSE = 48'h01_80_C2_00_00_01;

  logic [7:0] frame_buf [0:255];

  // Output monitor, sampling 1 time unit after each rising edge
  int mon_cnt, eof_cnt, eof_cyc, last_out_cyc, pv_cnt, ov_cnt;
  int cap_drop, cap_trunc, cap_crc, cap_q;
  always begin
    @(posedge rx_clk);
    #1;
    if (out_eof) begin
      chk("eof_excl", 32'(out_valid), 32'd0);
      eof_cnt++;
      eof_cyc   = cyc;
      cap_drop  = 32'(out_drop);
      cap_trunc = 32'(out_trunc);
      cap_crc   = 32'(out_crc_err);
    end
    if (out_valid) begin
      if (mon_cnt < 256) chk("data", 32'(out_data), 32'(frame_buf[mon_cnt]));
      mon_cnt++;
      last_out_cyc = cyc;
    end
    if (pause_valid) begin
      pv_cnt++;
      cap_q = 32'(pause_quanta);
    end
    if (overrun) ov_cnt++;
  end

  task automatic mon_clear();
    mon_cnt = 0; eof_cnt = 0; eof_cyc = 0; last_out_cyc = 0;
    pv_cnt = 0; ov_cnt = 0; cap_drop = 0; cap_trunc = 0; cap_crc = 0; cap_q = 0;
  endtask

  // da: 0 own, 1 broadcast, 2 pause (with pause opcode/quanta), 3 other unicast
  task automatic build(input int len, input int da, input int q);
    logic [47:0] d;
    logic [47:0] sh;
    logic [15:0] qv;
    logic [7:0]  ib;
    qv = 16'(q);
    case (da)
      0: d = MAC_OWN;
      1: d = 48'hFF_FF_FF_FF_FF_FF;
      2: d = MAC_PAUSE;
      default: d = MAC_OTHER;
    endcase
    for (int i = 0; i < 256; i++) begin
      ib = 8'(i);
      frame_buf[i] = ib ^ 8'h5A;
      if (i < 6) begin
        sh = d >> (8 * (5 - i));
        frame_buf[i] = sh[7:0];
      end
      if (da == 2) begin
        if (i == 12) frame_buf[i] = 8'h88;
        if (i == 13) frame_buf[i] = 8'h08;
        if (i == 14) frame_buf[i] = 8'h00;
        if (i == 15) frame_buf[i] = 8'h01;
        if (i == 16) frame_buf[i] = qv[15:8];
        if (i == 17) frame_buf[i] = qv[7:0];
      end
    end
  endtask

  int t_last;  // cycle in which the last byte was presented

  // Send len bytes (or stop_at bytes without in_last when stop_at > 0)
  task automatic send_frame(input int len, input int gap, input int crc, input int inj, input int stop_at);
    int nb;
    nb = (stop_at > 0) ? stop_at : len;
    for (int i = 0; i < nb; i++) begin
      if (gap != 0 && i == 20) begin
        @(negedge rx_clk);
        in_valid = 1'b0; in_last = 1'b0;
        repeat (2) @(negedge rx_clk);
      end else begin
        @(negedge rx_clk);
      end
      in_valid   = 1'b1;
      in_data    = frame_buf[i];
      in_last    = (stop_at == 0) && (i == len - 1);
      in_crc_err = (stop_at == 0) && (i == len - 1) && (crc != 0);
    end
    @(posedge rx_clk);
    #1;
    t_last = cyc - 1;
    @(negedge rx_clk);
    in_valid = 1'b0; in_last = 1'b0; in_crc_err = 1'b0;
    if (inj != 0) begin
      in_valid = 1'b1;
      in_data  = 8'hEE;
      @(negedge rx_clk);
      in_valid = 1'b0;
    end
  endtask

  typedef struct {
    int len, da, crcfwd, prom, bc_rej, fce, paufwd, crc, gap, max_fl, q;
    int e_cnt, e_drop, e_trunc, e_crc, e_pv;
  } vec_t;

  vec_t vecs [18];

  task automatic run_vec(input vec_t v);
    ether_en = 1'b1;
    crcfwd   = v.crcfwd[0];
    prom     = v.prom[0];
    bc_rej   = v.bc_rej[0];
    fce      = v.fce[0];
    paufwd   = v.paufwd[0];
    max_fl   = 14'(v.max_fl);
    build(v.len, v.da, v.q);
    mon_clear();
    send_frame(v.len, v.gap, v.crc, 0, 0);
    repeat (12) @(negedge rx_clk);
    chk("out_count", mon_cnt, v.e_cnt);
    chk("eof_count", eof_cnt, 1);
    chk("eof_delay", eof_cyc - t_last, (v.crcfwd != 0) ? 6 : 2);
    chk("drop", cap_drop, v.e_drop);
    chk("trunc", cap_trunc, v.e_trunc);
    chk("crc_err", cap_crc, v.e_crc);
    chk("pause_cnt", pv_cnt, v.e_pv);
    if (v.e_pv != 0) chk("pause_quanta", cap_q, v.q);
    chk("overrun_cnt", ov_cnt, 0);
    if (v.e_cnt > 0 && v.e_trunc == 0)
      chk("last_out_cyc", last_out_cyc - t_last, (v.crcfwd != 0) ? 5 : 1);
  endtask

  initial begin
    //            len  da cf pr bc fc pf cr gp maxfl  q      cnt dr tr ce pv
    vecs[0]  = '{ 64,  0, 0, 0, 0, 0, 0, 0, 0, 1518, 0,      60, 0, 0, 0, 0};
    vecs[1]  = '{ 64,  0, 1, 0, 0, 0, 0, 0, 0, 1518, 0,      64, 0, 0, 0, 0};
    vecs[2]  = '{ 64,  1, 0, 0, 1, 0, 0, 0, 0, 1518, 0,      60, 1, 0, 0, 0};
    vecs[3]  = '{ 64,  1, 0, 1, 1, 0, 0, 0, 0, 1518, 0,      60, 0, 0, 0, 0};
    vecs[4]  = '{100,  0, 1, 0, 0, 0, 0, 0, 0,   80, 0,      80, 1, 1, 0, 0};
    vecs[5]  = '{ 64,  2, 0, 0, 0, 1, 0, 0, 0, 1518, 'h1234, 60, 1, 0, 0, 1};
    vecs[6]  = '{ 64,  2, 0, 0, 0, 1, 1, 0, 0, 1518, 'h5678, 60, 0, 0, 0, 1};
    vecs[7]  = '{ 64,  0, 0, 0, 0, 0, 0, 1, 0, 1518, 0,      60, 1, 0, 1, 0};
    vecs[8]  = '{ 40,  0, 0, 0, 0, 0, 0, 0, 0, 1518, 0,      36, 1, 0, 0, 0};
    vecs[9]  = '{ 64,  3, 0, 0, 0, 0, 0, 0, 0, 1518, 0,      60, 1, 0, 0, 0};
    vecs[10] = '{  4,  0, 1, 0, 0, 0, 0, 0, 0, 1518, 0,       0, 1, 0, 0, 0};
    vecs[11] = '{ 64,  2, 0, 0, 0, 0, 0, 0, 0, 1518, 'h0042, 60, 0, 0, 0, 0};
    vecs[12] = '{ 64,  2, 0, 0, 0, 1, 0, 1, 0, 1518, 'h0042, 60, 1, 0, 1, 0};
    vecs[13] = '{ 65,  0, 1, 0, 0, 0, 0, 0, 0,   64, 0,      64, 1, 1, 0, 0};
    vecs[14] = '{ 64,  0, 1, 0, 0, 0, 0, 0, 0,   64, 0,      64, 0, 0, 0, 0};
    vecs[15] = '{ 64,  0, 1, 0, 0, 0, 0, 0, 1, 1518, 0,      64, 0, 0, 0, 0};
    vecs[16] = '{ 64,  0, 0, 0, 0, 0, 0, 0, 0,   62, 0,      60, 1, 1, 0, 0};
    vecs[17] = '{ 64,  1, 0, 0, 0, 0, 0, 0, 0, 1518, 0,      60, 0, 0, 0, 0};

    rst = 1'b1; ether_en = 1'b1; prom = 1'b0; bc_rej = 1'b0; fce = 1'b0;
    paufwd = 1'b0; crcfwd = 1'b0; max_fl = 14'd1518; mac_addr = MAC_OWN;
    in_valid = 1'b0; in_data = 8'd0; in_last = 1'b0; in_crc_err = 1'b0;
    mon_clear();
    repeat (3) @(negedge rx_clk);
    rst = 1'b0;
    @(negedge rx_clk);

    // Reset state
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_eof", 32'(out_eof), 32'd0);
    chk("rst_out_drop", 32'(out_drop), 32'd0);
    chk("rst_pause_valid", 32'(pause_valid), 32'd0);
    chk("rst_pause_quanta", 32'(pause_quanta), 32'd0);
    chk("rst_overrun", 32'(overrun), 32'd0);

    for (int i = 0; i < 18; i++) run_vec(vecs[i]);

    // Disabled receiver: no activity at all
    ether_en = 1'b0; crcfwd = 1'b0; prom = 1'b1;
    build(64, 0, 0);
    mon_clear();
    send_frame(64, 0, 0, 0, 0);
    repeat (12) @(negedge rx_clk);
    chk("dis_out_count", mon_cnt, 0);
    chk("dis_eof_count", eof_cnt, 0);
    chk("dis_pause_cnt", pv_cnt, 0);
    ether_en = 1'b1; prom = 1'b0;

    // Reset mid-frame at byte 30: no end strobe, quanta cleared, next frame fine
    build(64, 0, 0);
    mon_clear();
    send_frame(64, 0, 0, 0, 30);
    rst = 1'b1;
    repeat (2) @(negedge rx_clk);
    rst = 1'b0;
    repeat (10) @(negedge rx_clk);
    chk("midrst_eof_count", eof_cnt, 0);
    chk("midrst_pause_quanta", 32'(pause_quanta), 32'd0);
    run_vec(vecs[0]);

    // Byte injected during FLUSH: overrun pulse, frame output unchanged
    crcfwd = 1'b1; max_fl = 14'd1518;
    build(64, 0, 0);
    mon_clear();
    send_frame(64, 0, 0, 1, 0);
    repeat (12) @(negedge rx_clk);
    chk("ovr_overrun_cnt", ov_cnt, 1);
    chk("ovr_out_count", mon_cnt, 64);
    chk("ovr_eof_count", eof_cnt, 1);
    chk("ovr_eof_delay", eof_cyc - t_last, 6);
    chk("ovr_drop", cap_drop, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: bench did not complete");
    $fatal(1);
  end

endmodule
